uart_calc_parser: RTL and testbench

- Downstream of the UART receive stage. Consumes received ASCII bytes and parses the expression `<operandA><op><operandB><term>`.
- Computes the result and presents it with a valid/ready handshake to the transmit/formatting stage.
- Operands are unsigned decimal. Results are unsigned OPW-bit, with an error code.

---
 rtl/calc_pkg.sv | 70 +++++++
 rtl/calc_div.sv | 63 ++++++
 rtl/uart_calc_parser.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_calc_parser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the UART calculator parser.
// CALC_DIV_EN adds '/' as an operator and the DIV state.
package calc_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SP    = 8'h20;

  typedef enum logic [2:0] {
    ST_OPA   = 3'd0,
    ST_OPB   = 3'd1,
    ST_CALC  = 3'd2,
`ifdef CALC_DIV_EN
    ST_DIV   = 3'd3,
`endif
    ST_OUT   = 3'd4,
    ST_FLUSH = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_OVF    = 2'd1;
  localparam logic [1:0] ERR_SYNTAX = 2'd2;
  localparam logic [1:0] ERR_DIV0   = 2'd3;

  typedef enum logic [2:0] {
    BC_DIGIT = 3'd0,
    BC_OP    = 3'd1,
    BC_TERM  = 3'd2,
    BC_SPACE = 3'd3,
    BC_BAD   = 3'd4
  } byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t c;
    if (b >= ASCII_0 && b <= ASCII_9) c = BC_DIGIT;
    else if (b == ASCII_PLUS || b == ASCII_MINUS || b == ASCII_STAR) c = BC_OP;
`ifdef CALC_DIV_EN
    else if (b == ASCII_SLASH) c = BC_OP;
`endif
    else if (b == ASCII_EQ || b == ASCII_CR) c = BC_TERM;
    else if (b == ASCII_SP) c = BC_SPACE;
    else c = BC_BAD;
    return c;
  endfunction

  function automatic op_t decode_op(input logic [7:0] b);
    op_t o;
    case (b)
      ASCII_MINUS: o = OP_SUB;
      ASCII_STAR:  o = OP_MUL;
      ASCII_SLASH: o = OP_DIV;
      default:     o = OP_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_div.sv
// Sequential restoring divider: one quotient bit per cycle, OPW cycles total.
// The first step runs on the start cycle so done pulses after exactly OPW edges.
module calc_div #(
  parameter int OPW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] dividend,
  input  logic [OPW-1:0] divisor,
  output logic [OPW-1:0] quotient,
  output logic           done
);

  localparam int CNTW = $clog2(OPW + 1);

  logic [OPW-1:0]  rem_q, rem_d;
  logic [OPW-1:0]  quo_q, quo_d;
  logic [OPW-1:0]  dvs_q, dvs_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [OPW-1:0]  src_rem, src_quo;
  logic [OPW:0]    shifted, trial;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    dvs_d   = start ? divisor : dvs_q;
    shifted = {src_rem, src_quo[OPW-1]};
    // Top bit of trial set means the partial remainder was below the divisor.
    trial   = shifted - {1'b0, dvs_d};
    if (start || cnt_q != '0) begin
      rem_d  = trial[OPW] ? shifted[OPW-1:0] : trial[OPW-1:0];
      quo_d  = {src_quo[OPW-2:0], ~trial[OPW]};
      cnt_d  = start ? CNTW'(OPW - 1) : cnt_q - CNTW'(1);
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/uart_calc_parser.sv
// Parses "<A><op><B><term>" from received ASCII bytes and hands back one result.
// CALC_DIV_EN enables '/' via the calc_div restoring divider.
module uart_calc_parser
  import calc_pkg::*;
#(
  parameter int OPW    = 16,
  parameter int MAXDIG = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [OPW-1:0] res_data,
  output logic [1:0]     res_err,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           busy,
  output logic           drop
);

  localparam int CW = $clog2(MAXDIG + 1);

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [OPW-1:0] acc_a_q, acc_a_d;
  logic [OPW-1:0] acc_b_q, acc_b_d;
  logic [CW-1:0]  dcnt_q, dcnt_d;
  logic           ovf_q, ovf_d;
  logic [OPW-1:0] res_data_q, res_data_d;
  logic [1:0]     res_err_q, res_err_d;
  logic           res_valid_q, res_valid_d;
  logic           drop_q, drop_d;

  byte_class_t      cls;
  logic [OPW-1:0]   cur_acc;
  logic [OPW+3:0]   acc_wide;
  logic [OPW:0]     sum_w;
  logic [OPW-1:0]   diff_w;
  logic [2*OPW-1:0] prod_w;

  assign sum_w  = {1'b0, acc_a_q} + {1'b0, acc_b_q};
  assign diff_w = acc_a_q - acc_b_q;
  assign prod_w = {{OPW{1'b0}}, acc_a_q} * {{OPW{1'b0}}, acc_b_q};
  assign busy   = (state_q == ST_CALC) || (state_q == ST_OUT)
`ifdef CALC_DIV_EN
                  || (state_q == ST_DIV)
`endif
                  ;

`ifdef CALC_DIV_EN
  logic           div_start;
  logic [OPW-1:0] div_quo;
  logic           div_done;

  calc_div #(.OPW(OPW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_a_q),
    .divisor  (acc_b_q),
    .quotient (div_quo),
    .done     (div_done)
  );
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    dcnt_d      = dcnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    drop_d      = drop_q | (rx_valid & busy);
`ifdef CALC_DIV_EN
    div_start   = 1'b0;
`endif
    cls      = classify(rx_data);
    cur_acc  = (state_q == ST_OPB) ? acc_b_q : acc_a_q;
    // acc*10 + digit, kept 4 bits wider so overflow past OPW is visible.
    acc_wide = ({4'b0, cur_acc} << 3) + ({4'b0, cur_acc} << 1)
             + {{OPW{1'b0}}, rx_data[3:0]};

    case (state_q)
      ST_OPA, ST_OPB: begin
        if (rx_valid) begin
          case (cls)
            BC_DIGIT: begin
              if (dcnt_q == CW'(MAXDIG)) begin
                state_d = ST_FLUSH;
              end else begin
                if (state_q == ST_OPA) acc_a_d = acc_wide[OPW-1:0];
                else                   acc_b_d = acc_wide[OPW-1:0];
                dcnt_d = dcnt_q + CW'(1);
                if (|acc_wide[OPW+3:OPW]) ovf_d = 1'b1;
              end
            end
            BC_OP: begin
              if (state_q == ST_OPA && dcnt_q != '0) begin
                op_d    = decode_op(rx_data);
                dcnt_d  = '0;
                state_d = ST_OPB;
              end else begin
                state_d = ST_FLUSH;
              end
            end
            BC_TERM: begin
              if (state_q == ST_OPB && dcnt_q != '0) begin
                state_d = ST_CALC;
              end else begin
                state_d    = ST_OUT;
                res_data_d = '0;
                res_err_d  = ERR_SYNTAX;
              end
            end
            BC_SPACE: ;
            default: state_d = ST_FLUSH;
          endcase
        end
      end

      ST_FLUSH: begin
        if (rx_valid && cls == BC_TERM) begin
          state_d    = ST_OUT;
          res_data_d = '0;
          res_err_d  = ERR_SYNTAX;
        end
      end

      ST_CALC: begin
        state_d   = ST_OUT;
        res_err_d = ovf_q ? ERR_OVF : ERR_OK;
        case (op_q)
          OP_ADD: begin
            res_data_d = sum_w[OPW-1:0];
            if (sum_w[OPW]) res_err_d = ERR_OVF;
          end
          OP_SUB: begin
            res_data_d = diff_w;
            if (acc_a_q < acc_b_q) res_err_d = ERR_OVF;
          end
          OP_MUL: begin
            res_data_d = prod_w[OPW-1:0];
            if (|prod_w[2*OPW-1:OPW]) res_err_d = ERR_OVF;
          end
`ifdef CALC_DIV_EN
          OP_DIV: begin
            if (acc_b_q == '0) begin
              res_data_d = '1;
              res_err_d  = ERR_DIV0;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end
`endif
          default: begin
            res_data_d = '0;
            res_err_d  = ERR_SYNTAX;
          end
        endcase
      end

`ifdef CALC_DIV_EN
      ST_DIV: begin
        if (div_done) begin
          state_d    = ST_OUT;
          res_data_d = div_quo;
          res_err_d  = ovf_q ? ERR_OVF : ERR_OK;
        end
      end
`endif

      ST_OUT: begin
        // valid rises one cycle after entering OUT; result regs are already stable.
        res_valid_d = 1'b1;
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          acc_a_d     = '0;
          acc_b_d     = '0;
          dcnt_d      = '0;
          ovf_d       = 1'b0;
          state_d     = ST_OPA;
        end
      end

      default: state_d = ST_OPA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OPA;
      op_q        <= OP_ADD;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      dcnt_q      <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
      res_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      dcnt_q      <= dcnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_uart_calc_parser.sv
// Bench for uart_calc_parser: byte driver, result scoreboard, latency/hold/reset checks.
// Division cases are built when CALC_DIV_EN is defined.
module tb_uart_calc_parser;

  localparam int OPW = 16;

  logic           clk;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [OPW-1:0] res_data;
  logic [1:0]     res_err;
  logic           res_valid;
  logic           res_ready;
  logic           busy;
  logic           drop;

  logic [OPW+1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  uart_calc_parser #(.OPW(OPW), .MAXDIG(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .drop      (drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // drivers: called at #1 after a posedge; return at #1 after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // sends an expression, expects the result via the scoreboard, checks latency
  task automatic run_expr(input string tag, input string s, input logic [1:0] e,
                          input logic [OPW-1:0] d, input int lat);
    int n;
    exp_q.push_back({e, d});
    send_str(s);
    n = 0;
    while (res_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    check_eq({tag, " valid"}, res_valid, 1);
    if (lat >= 0) check_eq({tag, " latency"}, n, lat);
    @(posedge clk); #1;
    check_eq({tag, " pulse"}, res_valid, 0);
    check_eq({tag, " idle"}, busy, 0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      check_eq("exp_avail", exp_q.size(), 1);
      if (exp_q.size() > 0) check_eq("result", {res_err, res_data}, exp_q.pop_front());
    end
  end

  initial begin
    longint a, b, p;
    int sel, n, seen;
    logic [1:0] e;
    logic [OPW-1:0] d;
    logic [7:0] ch;
    bit stable;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; res_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    check_eq("rst res_valid", res_valid, 0);
    check_eq("rst res_data", res_data, 0);
    check_eq("rst res_err", res_err, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst drop", drop, 0);

    // basic add with explicit latency and busy in CALC
    exp_q.push_back({2'd0, 16'd42});
    send_str("12+30=");
    check_eq("add busy calc", busy, 1);
    check_eq("add t1 valid", res_valid, 0);
    @(posedge clk); #1;
    check_eq("add t1 valid", res_valid, 0);
    @(posedge clk); #1;
    check_eq("add t2 valid", res_valid, 1);
    @(posedge clk); #1;
    check_eq("add t3 valid", res_valid, 0);
    check_eq("add t3 idle", busy, 0);

    run_expr("sub_cr", "5-7\015", 2'd1, 16'hFFFE, 2);
    run_expr("mul_ovf", "300*300=", 2'd1, 16'h5F90, 2);
    run_expr("bad_char", "1a+2=", 2'd2, 16'd0, -1);
    run_expr("after_bad", "3+4=", 2'd0, 16'd7, 2);
    run_expr("six_digits", "123456+1=", 2'd2, 16'd0, -1);
    run_expr("add_carry", "65535+1=", 2'd1, 16'd0, 2);
    run_expr("op_first", "+5=", 2'd2, 16'd0, -1);
    run_expr("term_in_a", "12=", 2'd2, 16'd0, -1);
    run_expr("empty_b", "12+=", 2'd2, 16'd0, -1);
    run_expr("spaces", " 7 + 8 =", 2'd0, 16'd15, 2);
    run_expr("acc_ovf", "99999+0=", 2'd1, 16'd34463, 2);
    run_expr("five_digits", "65535*1=", 2'd0, 16'hFFFF, 2);
    check_eq("drop clean", drop, 0);

    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      if (k < 4) b = $urandom_range(0, 300);
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        ch = "+"; p = a + b;
        e = (p > 65535) ? 2'd1 : 2'd0;
      end else if (sel == 1) begin
        ch = "-"; p = a - b;
        e = (a < b) ? 2'd1 : 2'd0;
      end else begin
        ch = "*"; p = a * b;
        e = (p > 65535) ? 2'd1 : 2'd0;
      end
      d = p[OPW-1:0];
      run_expr($sformatf("rand%0d", k), $sformatf("%0d%c%0d=", a, ch, b), e, d, 2);
    end

    // hold with res_ready low; a byte during OUT is dropped
    res_ready = 1'b0;
    exp_q.push_back({2'd0, 16'd6});
    send_str("2*3=");
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("hold valid", res_valid, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send_byte("9");
      else begin @(posedge clk); #1; end
      if (res_valid !== 1'b1 || res_data !== 16'd6 || res_err !== 2'd0) stable = 1'b0;
    end
    check_eq("hold stable", stable, 1);
    check_eq("hold drop", drop, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hold release valid", res_valid, 0);
    check_eq("hold release idle", busy, 0);
    run_expr("after_hold", "1+1=", 2'd0, 16'd2, 2);
    check_eq("drop sticky", drop, 1);

    // rst while a result is held in OUT
    res_ready = 1'b0;
    send_str("4+4=");
    idle(4);
    check_eq("out_rst pre valid", res_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("out_rst valid", res_valid, 0);
    check_eq("out_rst data", res_data, 0);
    check_eq("out_rst drop", drop, 0);
    check_eq("out_rst busy", busy, 0);
    res_ready = 1'b1;
    run_expr("after_out_rst", "9+1=", 2'd0, 16'd10, 2);

`ifdef CALC_DIV_EN
    run_expr("div", "100/7=", 2'd0, 16'd14, 18);
    run_expr("div_zero", "9/0=", 2'd3, 16'hFFFF, -1);
    run_expr("div_big", "65535/255=", 2'd0, 16'd257, 18);
    run_expr("div_small", "3/9=", 2'd0, 16'd0, 18);
    send_str("60000/3=");
    idle(5);
    check_eq("div_rst busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check_eq("div_rst no result", seen, 0);
    check_eq("div_rst idle", busy, 0);
    run_expr("after_div_rst", "8/2=", 2'd0, 16'd4, 18);
`else
    run_expr("slash_bad", "9/3=", 2'd2, 16'd0, -1);
    run_expr("after_slash", "9-3=", 2'd0, 16'd6, 2);
`endif

    idle(3);
    check_eq("queue drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
